// File: rtl/apb_regif_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_regif_pkg
// Brief    : Shared types, widths and helpers for the APB register interface.
// Revision : 1.0 - initial release
// ============================================================================
package apb_regif_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  // Bus-side FSM state
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Expand one strobe bit per byte lane into a full-width bit mask
  function automatic logic [APB_DATA_W-1:0] lane_mask(input logic [APB_STRB_W-1:0] strb);
    logic [APB_DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < APB_STRB_W; b++) begin
      m[8*b +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module   : apb_wait_ctr
// Brief    : Wait-state counter for the APB ACCESS phase. Clear has priority
//            over enable; done is high while the count equals WAIT_STATES.
// Revision : 1.0 - initial release
// ============================================================================
module apb_wait_ctr #(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam logic [3:0] c_wait_max = 4'(WAIT_STATES);

  logic [3:0] r_cnt;

  // Count ACCESS cycles; cleared whenever the transfer is not in a wait cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_done = (r_cnt == c_wait_max);

endmodule
`default_nettype wire

// File: rtl/apb_slave_regif.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_regif
// Brief    : APB slave decoding transfers into NUM_REGS 32-bit RW registers,
//            with programmable wait states and pslverr on bad addresses.
//            Optional macro APB_PSTRB_EN enables per-byte write strobes;
//            without it pstrb is ignored and writes update all 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_regif
  import apb_regif_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int NUM_REGS    = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                         pclk,
  input  logic                         preset_n,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [APB_DATA_W-1:0]        pwdata,
  input  logic [APB_STRB_W-1:0]        pstrb,
  output logic [APB_DATA_W-1:0]        prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [APB_DATA_W*NUM_REGS-1:0] reg_q,
  output logic [NUM_REGS-1:0]          reg_wr
);

  apb_state_e             r_state;
  logic [NUM_REGS-1:0]    r_reg_wr;
  logic [ADDR_W-3:0]      w_idx;
  logic                   w_err;
  logic                   w_in_access;
  logic                   w_ctr_done;
  logic                   w_ctr_clr;
  logic                   w_ctr_en;
  logic                   w_complete;
  logic                   w_commit;
  logic [NUM_REGS-1:0]    w_sel;
  logic [APB_DATA_W-1:0]  w_wmask;
  logic [APB_DATA_W-1:0]  w_rd_word;

  // Address decode: word index plus misalignment / out-of-range error
  assign w_idx = paddr[ADDR_W-1:2];
  assign w_err = (paddr[1:0] != 2'b00) || (32'(w_idx) >= 32'(NUM_REGS));

  // The transfer completes only while still selected; dropping psel early aborts it
  assign w_in_access = (r_state == ST_ACCESS);
  assign w_complete  = w_in_access && psel && w_ctr_done;
  assign w_commit    = w_complete && pwrite && !w_err;
  assign w_ctr_en    = w_in_access && psel;
  assign w_ctr_clr   = !w_in_access || !psel || w_ctr_done;

`ifdef APB_PSTRB_EN
  assign w_wmask = lane_mask(pstrb);
`else
  logic w_unused_pstrb;
  assign w_unused_pstrb = ^pstrb;
  assign w_wmask        = {APB_DATA_W{1'b1}};
`endif

  apb_wait_ctr #(
    .WAIT_STATES(WAIT_STATES)
  ) u_wait_ctr (
    .clk   (pclk),
    .rst_n (preset_n),
    .i_clr (w_ctr_clr),
    .i_en  (w_ctr_en),
    .o_done(w_ctr_done)
  );

  // Bus FSM: IDLE -> SETUP on setup phase, SETUP -> ACCESS on enable, back to IDLE on completion or abort
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (psel && !penable) r_state <= ST_SETUP;
        end
        ST_SETUP: begin
          if (!psel)        r_state <= ST_IDLE;
          else if (penable) r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (!psel || w_ctr_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Register bank: one word per index, written only on the completing edge
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
    logic [APB_DATA_W-1:0] r_reg;

    assign w_sel[i] = (32'(w_idx) == 32'(i));

    // Merge write data into the selected byte lanes
    always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
        r_reg <= '0;
      end else if (w_commit && w_sel[i]) begin
        r_reg <= (r_reg & ~w_wmask) | (pwdata & w_wmask);
      end
    end

    assign reg_q[APB_DATA_W*i +: APB_DATA_W] = r_reg;
  end

  // Write-strobe pulse to the core, one cycle after the committing edge
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      r_reg_wr <= '0;
    end else begin
      r_reg_wr <= w_commit ? w_sel : '0;
    end
  end

  // Read mux over the register bank
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_sel[i]) w_rd_word = reg_q[APB_DATA_W*i +: APB_DATA_W];
    end
  end

  assign reg_wr  = r_reg_wr;
  assign pready  = w_complete;
  assign pslverr = w_complete && w_err;
  assign prdata  = (w_complete && !pwrite && !w_err) ? w_rd_word : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_regif.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_regif
// Brief    : Directed self-checking bench; three instances with 0, 2 and 3
//            wait states share the bus, each selected by its own psel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_regif;

  localparam int D_W0 = 0;
  localparam int D_W2 = 1;
  localparam int D_W3 = 2;

  logic         clk;
  logic         preset_n;
  logic [2:0]   psel_v;
  logic         penable;
  logic         pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [31:0]  prdata_v  [3];
  logic         pready_v  [3];
  logic         pslverr_v [3];
  logic [127:0] reg_q_v   [3];
  logic [3:0]   reg_wr_v  [3];

  int n_checks;
  int n_errs;

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [3:0]  wp;

  apb_slave_regif #(.ADDR_W(8), .NUM_REGS(4), .WAIT_STATES(0)) u_dut_w0 (
    .pclk(clk), .preset_n(preset_n), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_v[0]), .pready(pready_v[0]),
    .pslverr(pslverr_v[0]), .reg_q(reg_q_v[0]), .reg_wr(reg_wr_v[0]));

  apb_slave_regif #(.ADDR_W(8), .NUM_REGS(4), .WAIT_STATES(2)) u_dut_w2 (
    .pclk(clk), .preset_n(preset_n), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_v[1]), .pready(pready_v[1]),
    .pslverr(pslverr_v[1]), .reg_q(reg_q_v[1]), .reg_wr(reg_wr_v[1]));

  apb_slave_regif #(.ADDR_W(8), .NUM_REGS(4), .WAIT_STATES(3)) u_dut_w3 (
    .pclk(clk), .preset_n(preset_n), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_v[2]), .pready(pready_v[2]),
    .pslverr(pslverr_v[2]), .reg_q(reg_q_v[2]), .reg_wr(reg_wr_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Full APB transfer to instance d; lat counts cycles from SETUP state up to and including pready
  task automatic xfer(input int d, input logic wr, input logic [7:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                      output int nlat, output logic [3:0] wrp);
    bit done;
    done  = 1'b0;
    rdata = '0;
    err   = 1'b0;
    nlat  = 0;
    @(posedge clk); #1;
    psel_v    = '0;
    psel_v[d] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = addr;
    pwdata    = data;
    pstrb     = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    while (!done && nlat < 40) begin
      @(negedge clk);
      nlat++;
      if (pready_v[d]) begin
        rdata = prdata_v[d];
        err   = pslverr_v[d];
        done  = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) check("timeout", 128'd0, 128'd1);
    @(posedge clk); #1;
    psel_v  = '0;
    penable = 1'b0;
    @(negedge clk);
    wrp = reg_wr_v[d];
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    preset_n = 1'b0;
    psel_v   = '0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = '0;
    pwdata   = '0;
    pstrb    = 4'hF;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pready",  128'(pready_v[D_W0]),  128'd0);
    check("rst_pslverr", 128'(pslverr_v[D_W0]), 128'd0);
    check("rst_prdata",  128'(prdata_v[D_W0]),  128'd0);
    check("rst_reg_q",   reg_q_v[D_W0],         128'd0);
    check("rst_reg_wr",  128'(reg_wr_v[D_W0]),  128'd0);
    @(posedge clk); #1;
    preset_n = 1'b1;

    // W=0 write then read of 0x04
    xfer(D_W0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd, er, lat, wp);
    check("t1_wr_lat",    128'(lat), 128'd2);
    check("t1_wr_err",    128'(er),  128'd0);
    check("t1_wr_pulse",  128'(wp),  128'b0010);
    @(negedge clk);
    check("t1_pulse_end", 128'(reg_wr_v[D_W0]), 128'd0);
    check("t1_reg_q",     reg_q_v[D_W0], {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});
    xfer(D_W0, 1'b0, 8'h04, 32'h0, 4'hF, rd, er, lat, wp);
    check("t1_rd_lat",    128'(lat), 128'd2);
    check("t1_rd_data",   128'(rd),  128'hDEADBEEF);
    check("t1_rd_err",    128'(er),  128'd0);
    check("t1_rd_pulse",  128'(wp),  128'd0);

    // W=3 write then read of 0x00
    xfer(D_W3, 1'b1, 8'h00, 32'h000000A5, 4'hF, rd, er, lat, wp);
    check("t2_wr_lat",  128'(lat), 128'd5);
    check("t2_wr_pulse", 128'(wp), 128'b0001);
    xfer(D_W3, 1'b0, 8'h00, 32'h0, 4'hF, rd, er, lat, wp);
    check("t2_rd_lat",  128'(lat), 128'd5);
    check("t2_rd_data", 128'(rd),  128'h000000A5);

    // Bad accesses: out-of-range read and misaligned write
    xfer(D_W0, 1'b0, 8'h10, 32'h0, 4'hF, rd, er, lat, wp);
    check("t3_oor_err",  128'(er),  128'd1);
    check("t3_oor_data", 128'(rd),  128'd0);
    check("t3_oor_lat",  128'(lat), 128'd2);
    xfer(D_W0, 1'b1, 8'h06, 32'hFFFFFFFF, 4'hF, rd, er, lat, wp);
    check("t3_mis_err",   128'(er), 128'd1);
    check("t3_mis_pulse", 128'(wp), 128'd0);
    check("t3_mis_reg_q", reg_q_v[D_W0], {32'h0, 32'h0, 32'hDEADBEEF, 32'h0});

    // Highest valid register 0x0C
    xfer(D_W0, 1'b1, 8'h0C, 32'h0BADF00D, 4'hF, rd, er, lat, wp);
    check("t3_top_err",   128'(er), 128'd0);
    check("t3_top_pulse", 128'(wp), 128'b1000);
    xfer(D_W0, 1'b0, 8'h0C, 32'h0, 4'hF, rd, er, lat, wp);
    check("t3_top_data",  128'(rd), 128'h0BADF00D);
    check("t3_top_reg_q", reg_q_v[D_W0], {32'h0BADF00D, 32'h0, 32'hDEADBEEF, 32'h0});

    // Abort: W=2, preload reg 2, then drop psel in the first ACCESS cycle
    xfer(D_W2, 1'b1, 8'h08, 32'h12345678, 4'hF, rd, er, lat, wp);
    check("t4_pre_lat", 128'(lat), 128'd4);
    @(posedge clk); #1;
    psel_v[D_W2] = 1'b1;
    penable      = 1'b0;
    pwrite       = 1'b1;
    paddr        = 8'h08;
    pwdata       = 32'h00000055;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    check("t4_no_pready", 128'(pready_v[D_W2]), 128'd0);
    psel_v  = '0;
    penable = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t4_abort_pready", 128'(pready_v[D_W2]), 128'd0);
    end
    check("t4_abort_reg_wr", 128'(reg_wr_v[D_W2]), 128'd0);
    check("t4_abort_reg2",   128'(reg_q_v[D_W2][95:64]), 128'h12345678);
    xfer(D_W2, 1'b0, 8'h08, 32'h0, 4'hF, rd, er, lat, wp);
    check("t4_after_lat",  128'(lat), 128'd4);
    check("t4_after_data", 128'(rd),  128'h12345678);

    // Byte strobes on reg 0
    xfer(D_W0, 1'b1, 8'h00, 32'h11223344, 4'hF, rd, er, lat, wp);
    xfer(D_W0, 1'b1, 8'h00, 32'hAABBCCDD, 4'b0101, rd, er, lat, wp);
    xfer(D_W0, 1'b0, 8'h00, 32'h0, 4'hF, rd, er, lat, wp);
`ifdef APB_PSTRB_EN
    check("t6_strb_data", 128'(rd), 128'h11BB33DD);
`else
    check("t6_strb_data", 128'(rd), 128'hAABBCCDD);
`endif
    xfer(D_W0, 1'b1, 8'h00, 32'hFFFFFFFF, 4'b0000, rd, er, lat, wp);
    check("t6_zero_err",   128'(er), 128'd0);
    check("t6_zero_pulse", 128'(wp), 128'b0001);
    xfer(D_W0, 1'b0, 8'h00, 32'h0, 4'hF, rd, er, lat, wp);
`ifdef APB_PSTRB_EN
    check("t6_zero_data", 128'(rd), 128'h11BB33DD);
`else
    check("t6_zero_data", 128'(rd), 128'hFFFFFFFF);
`endif

    // Reset asserted on the completing cycle of a W=2 write
    @(posedge clk); #1;
    psel_v[D_W2] = 1'b1;
    penable      = 1'b0;
    pwrite       = 1'b1;
    paddr        = 8'h0C;
    pwdata       = 32'hCAFEF00D;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0;
    while (!pready_v[D_W2] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("t5_pre_pready", 128'(pready_v[D_W2]), 128'd1);
    preset_n = 1'b0;
    #1;
    check("t5_rst_pready",  128'(pready_v[D_W2]),  128'd0);
    check("t5_rst_pslverr", 128'(pslverr_v[D_W2]), 128'd0);
    check("t5_rst_prdata",  128'(prdata_v[D_W2]),  128'd0);
    psel_v  = '0;
    penable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    preset_n = 1'b1;
    @(negedge clk);
    check("t5_reg_q_w2", reg_q_v[D_W2], 128'd0);
    check("t5_reg_q_w0", reg_q_v[D_W0], 128'd0);
    check("t5_reg_q_w3", reg_q_v[D_W3], 128'd0);
    check("t5_reg_wr",   128'(reg_wr_v[D_W2]), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
